// File: rtl/multiply_seq.sv
// rtl/multiply_seq.sv - iterative shift-add multiplier, one multiplier bit per cycle (optional MULT_SIGNED_EN)
module multiply_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
`ifdef MULT_SIGNED_EN
    input  logic                 signed_op,
`endif
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     mcand_reg;
    logic [2*WIDTH:0]     acc;
    logic [CW-1:0]        count;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH:0]     acc_added;
    logic [2*WIDTH:0]     acc_next;
    logic                 last_iter;
    logic                 accept;
    logic [2*WIDTH-1:0]   result;

`ifdef MULT_SIGNED_EN
    logic                 neg_flag;
    logic                 a_neg;
    logic                 b_neg;

    // Signed requests are converted to magnitudes so the iteration stays unsigned
    always_comb begin
        a_neg = signed_op & multiplicand[WIDTH-1];
        b_neg = signed_op & multiplier[WIDTH-1];
        a_mag = a_neg ? (~multiplicand + WIDTH'(1)) : multiplicand;
        b_mag = b_neg ? (~multiplier + WIDTH'(1)) : multiplier;
    end
`else
    // Unsigned build: operands are used as-is
    always_comb begin
        a_mag = multiplicand;
        b_mag = multiplier;
    end
`endif

    // One shift-add step; the (WIDTH+1)-bit sum keeps the carry in acc's top bit
    always_comb begin
        sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand_reg};
        acc_added = acc[0] ? {sum, acc[WIDTH-1:0]} : acc;
        acc_next  = acc_added >> 1;
        last_iter = (count == CW'(WIDTH - 1));
        accept    = start & ~abort;
`ifdef MULT_SIGNED_EN
        result    = neg_flag ? (~acc_next[2*WIDTH-1:0] + (2*WIDTH)'(1))
                             : acc_next[2*WIDTH-1:0];
`else
        result    = acc_next[2*WIDTH-1:0];
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = S_IDLE;
                end else if (last_iter) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: the product is written on the final iteration so it is valid while done is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg <= '0;
            acc       <= '0;
            count     <= '0;
            product   <= '0;
`ifdef MULT_SIGNED_EN
            neg_flag  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mcand_reg <= a_mag;
                        acc       <= {{(WIDTH+1){1'b0}}, b_mag};
                        count     <= '0;
`ifdef MULT_SIGNED_EN
                        neg_flag  <= a_neg ^ b_neg;
`endif
                    end
                end
                S_RUN: begin
                    if (!abort) begin
                        acc   <= acc_next;
                        count <= count + CW'(1);
                        if (last_iter) begin
                            product <= result;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiply_seq.sv
// tb/tb_multiply_seq.sv - self-checking bench for multiply_seq against an arithmetic reference
module tb_multiply_seq;

    localparam int WIDTH = 32;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic                 abort;
    logic                 signed_op;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    int checks;
    int errors;

    multiply_seq #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
`ifdef MULT_SIGNED_EN
        .signed_op    (signed_op),
`endif
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int restart_at, input string tag);
        logic [63:0] exp;
        logic [63:0] prev;
        logic [63:0] got;
        int busy_cnt;
        int done_cnt;
        int done_at;
        logic overlap;
        logic moved;
        exp = model(a, b, s);
        prev = product;
        multiplicand = a;
        multiplier = b;
        signed_op = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        multiplicand = $urandom;
        multiplier = $urandom;
        signed_op = 1'($urandom);
        busy_cnt = 0;
        done_cnt = 0;
        done_at = -1;
        overlap = 1'b0;
        moved = 1'b0;
        got = '0;
        for (int k = 0; k < WIDTH + 4; k++) begin
            if (k == restart_at) begin
                start = 1'b1;
                multiplicand = 32'd2;
                multiplier = 32'd2;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = k;
                    got = product;
                end
            end
            if (busy && done) overlap = 1'b1;
            if (busy && product !== prev) moved = 1'b1;
            tick();
        end
        start = 1'b0;
        check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(WIDTH));
        check({tag, ".done_count"}, 64'(done_cnt), 64'd1);
        check({tag, ".done_latency"}, 64'(done_at), 64'(WIDTH));
        check({tag, ".product"}, got, exp);
        check({tag, ".busy_done_overlap"}, 64'(overlap), 64'd0);
        check({tag, ".product_held_in_run"}, 64'(moved), 64'd0);
    endtask

    initial begin
        int done_seen;
        logic [31:0] ra;
        logic [31:0] rb;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        signed_op = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        tick();
        tick();
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.product", product, 64'd0);
        rst_n = 1'b1;
        tick();

        run_op(32'd3, 32'd5, 1'b0, -1, "mul_3x5");
        tick();
        tick();
        tick();
        check("stable_after_done", product, 64'h0000_0000_0000_000F);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, "mul_max");
        run_op(32'h1234_5678, 32'h0, 1'b0, -1, "mul_zero");

        run_op(32'd7, 32'd9, 1'b0, 10, "restart_ignored");
        check("restart_ignored.idle", 64'(busy), 64'd0);

        run_op(32'd3, 32'd5, 1'b0, -1, "pre_abort");
        multiplicand = 32'd11;
        multiplier = 32'd13;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 14; k++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort.busy_drop", 64'(busy), 64'd0);
        done_seen = 0;
        for (int k = 0; k < WIDTH + 4; k++) begin
            if (done || busy) done_seen++;
            tick();
        end
        check("abort.no_done", 64'(done_seen), 64'd0);
        check("abort.product_kept", product, 64'h0000_0000_0000_000F);
        run_op(32'd6, 32'd7, 1'b0, -1, "after_abort");

        multiplicand = 32'd9;
        multiplier = 32'd9;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle.busy", 64'(busy), 64'd0);
        tick();
        check("start_abort_idle.product", product, 64'd42);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 0) ra = 32'h8000_0000;
            if (i == 1) rb = 32'd1;
            run_op(ra, rb, 1'b0, -1, $sformatf("rand%0d", i));
        end

`ifdef MULT_SIGNED_EN
        run_op(32'hFFFF_FFFD, 32'd5, 1'b1, -1, "signed_neg3x5");
        run_op(32'hFFFF_FFFD, 32'd5, 1'b0, -1, "unsigned_neg3x5");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, -1, "signed_minmin");
        for (int i = 0; i < 8; i++) begin
            run_op($urandom, $urandom, 1'($urandom), -1, $sformatf("srand%0d", i));
        end
`endif

        multiplicand = 32'd100;
        multiplier = 32'd200;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 19; k++) tick();
        rst_n = 1'b0;
        #1;
        check("midrun_reset.busy", 64'(busy), 64'd0);
        check("midrun_reset.done", 64'(done), 64'd0);
        check("midrun_reset.product", product, 64'd0);
        tick();
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < WIDTH + 4; k++) begin
            if (done || busy) done_seen++;
            tick();
        end
        check("midrun_reset.no_done", 64'(done_seen), 64'd0);
        check("midrun_reset.product_zero", product, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
